// File: rtl/dmem_stall_ctrl_if.sv
// External data-memory handshake bundle: req/we/addr/wdata out from the
// controller, ack/rdata back from the slow memory.
interface dmem_stall_ctrl_if #(
    parameter int ADDR_W = 16
) ();
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/dmem_stall_ctrl.sv
// Stalls the single-cycle MIPS datapath around each load/store to a slow req/ack data memory.
// Optional macro DMEM_TIMEOUT_EN adds a WAIT timeout with sticky timeout_err.
//
//   state  | meaning
//   IDLE   | no access pending; accesses are issued from here
//   WAIT   | mem_req held, waiting for mem_ack (or timeout)
//   DONE   | datapath released for one cycle, latched read data presented
module dmem_stall_ctrl #(
    parameter int ADDR_W         = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite_in,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        PC_en,
    output logic        RegWrite_out,
    output logic        align_err,
`ifdef DMEM_TIMEOUT_EN
    output logic        timeout_err,
`endif
    dmem_stall_ctrl_if.master mem
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_rdata;
    logic              r_align_err;

    logic              w_access;
    logic              w_aligned;
    logic              w_issue;
    logic              w_misalign;
    logic              w_ack;
    logic              w_timeout;

    assign w_access   = MemRead | MemWrite;
    assign w_aligned  = (address[1:0] == 2'b00);
    assign w_issue    = (r_state == S_IDLE) && w_access && w_aligned;
    assign w_misalign = (r_state == S_IDLE) && w_access && !w_aligned;
    assign w_ack      = (r_state == S_WAIT) && mem.mem_ack;

`ifdef DMEM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_tmo_cnt;
    logic             r_timeout_err;

    // Down-counter loaded on WAIT entry; terminal count in WAIT without ack forces completion.
    assign w_timeout = (r_state == S_WAIT) && !mem.mem_ack && (r_tmo_cnt == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tmo_cnt     <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_tmo_cnt <= CNT_W'(TIMEOUT_CYCLES - 1);
            end else if ((r_state == S_WAIT) && (r_tmo_cnt != '0)) begin
                r_tmo_cnt <= r_tmo_cnt - 1'b1;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    assign w_timeout = 1'b0;
    wire [31:0] w_unused_timeout = TIMEOUT_CYCLES;
`endif

    wire w_unused_addr = ^{address[31:ADDR_W+2]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_next_state = S_WAIT;
                end else if (w_misalign) begin
                    w_next_state = S_DONE;
                end
            end
            S_WAIT: begin
                if (w_ack || w_timeout) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        PC_en        = 1'b1;
        RegWrite_out = RegWrite_in;
        read_data    = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_access) begin
                    PC_en        = 1'b0;
                    RegWrite_out = 1'b0;
                end
            end
            S_WAIT: begin
                PC_en        = 1'b0;
                RegWrite_out = 1'b0;
            end
            S_DONE:  read_data = r_rdata;
            default: ;
        endcase
    end

    // Request fields are captured once at issue; inputs are not looked at again during WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_rdata     <= 32'h0;
            r_align_err <= 1'b0;
        end else begin
            if (w_issue) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= MemWrite;
                r_mem_addr  <= address[ADDR_W+1:2];
                r_mem_wdata <= write_data;
            end else if (w_ack) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_rdata   <= r_mem_we ? 32'h0 : mem.mem_rdata;
            end else if (w_timeout) begin
                r_mem_req <= 1'b0;
                r_mem_we  <= 1'b0;
                r_rdata   <= 32'hDEAD_BEEF;
            end
            if (w_misalign) begin
                r_align_err <= 1'b1;
                r_rdata     <= 32'h0;
            end
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_wdata = r_mem_wdata;
    assign align_err     = r_align_err;

endmodule
